// File: rtl/inst_fetch.sv
// Instruction fetch stage: one-entry last-fetch buffer with a req/ack miss path to instruction memory.
// Defining INST_FETCH_ICACHE_EN adds a direct-mapped cache of 2^ICACHE_IDX one-word lines.
module inst_fetch #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned ICACHE_IDX  = 3
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        icache_flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall,
  output logic        fetch_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      f_addr_r;
  logic [31:0]      f_data_r;
  logic             f_valid_r;
  logic             f_err_r;
  logic [CNT_W-1:0] cnt_r;

  logic             aligned_s;
  logic             buf_hit_s;
  logic             cache_hit_s;
  logic [31:0]      cache_data_s;
  logic             start_s;
  logic             fill_s;
  logic             timeout_s;

  assign aligned_s = (pc[1:0] == 2'b00);
  assign buf_hit_s = f_valid_r && (f_addr_r == pc);
  // mem_req is high exactly while in REQ, so an ack anywhere else is ignored.
  assign fill_s    = (state_r == REQ) && mem_ack;
  assign timeout_s = (state_r == REQ) && !mem_ack && (cnt_r == CNT_LAST);

  // Hit/miss decode, fetch outputs and next state.
  always_comb begin
    state_nxt_s = state_r;
    inst        = 32'h0;
    inst_valid  = 1'b0;
    stall       = 1'b0;
    fetch_err   = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!aligned_s) begin
          inst_valid = 1'b1;
          fetch_err  = 1'b1;
        end else if (buf_hit_s) begin
          inst       = f_data_r;
          inst_valid = 1'b1;
          fetch_err  = f_err_r;
        end else if (cache_hit_s) begin
          inst       = cache_data_s;
          inst_valid = 1'b1;
        end else begin
          stall       = 1'b1;
          start_s     = 1'b1;
          state_nxt_s = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (fill_s || timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      default: begin
        stall       = 1'b1;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Bus request launch, completion or timeout, and the last-fetch buffer.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      f_addr_r  <= 32'h0;
      f_data_r  <= 32'h0;
      f_valid_r <= 1'b0;
      f_err_r   <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      mem_req   <= 1'b0;
      mem_addr  <= 32'h0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        // Invalidate the buffer so the overwritten f_addr cannot alias old data.
        f_addr_r  <= pc;
        f_valid_r <= 1'b0;
        f_err_r   <= 1'b0;
        cnt_r     <= {CNT_W{1'b0}};
        mem_req   <= 1'b1;
        mem_addr  <= {pc[31:2], 2'b00};
      end else if (fill_s) begin
        f_data_r  <= mem_rdata;
        f_valid_r <= 1'b1;
        f_err_r   <= 1'b0;
        mem_req   <= 1'b0;
      end else if (timeout_s) begin
        f_data_r  <= 32'h0;
        f_valid_r <= !icache_flush;
        f_err_r   <= 1'b1;
        mem_req   <= 1'b0;
      end else begin
        if (state_r == REQ) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        if (icache_flush) begin
          f_valid_r <= 1'b0;
        end
      end
    end
  end

`ifdef INST_FETCH_ICACHE_EN
  localparam int unsigned LINES = 1 << ICACHE_IDX;
  localparam int unsigned TAG_W = 30 - ICACHE_IDX;

  logic [TAG_W-1:0]      tag_r  [LINES];
  logic [31:0]           data_r [LINES];
  logic [LINES-1:0]      line_valid_r;
  logic [ICACHE_IDX-1:0] rd_idx_s;
  logic [ICACHE_IDX-1:0] wr_idx_s;

  assign rd_idx_s     = pc[ICACHE_IDX+1:2];
  assign wr_idx_s     = f_addr_r[ICACHE_IDX+1:2];
  assign cache_hit_s  = line_valid_r[rd_idx_s] && (tag_r[rd_idx_s] == pc[31:ICACHE_IDX+2]);
  assign cache_data_s = data_r[rd_idx_s];

  // Line valid bits; a flush on the fill edge wins over the fill.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      line_valid_r <= {LINES{1'b0}};
    end else if (icache_flush) begin
      line_valid_r <= {LINES{1'b0}};
    end else if (fill_s) begin
      line_valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // Tag and data storage, written only on an acked fill.
  always_ff @(posedge clk_cpu) begin
    if (fill_s) begin
      tag_r[wr_idx_s]  <= f_addr_r[31:ICACHE_IDX+2];
      data_r[wr_idx_s] <= mem_rdata;
    end
  end
`else
  logic [ICACHE_IDX-1:0] unused_idx_s;

  assign cache_hit_s  = 1'b0;
  assign cache_data_s = 32'h0;
  // Keeps ICACHE_IDX referenced in the buffer-only build.
  assign unused_idx_s = pc[ICACHE_IDX+1:2];
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, a reset-during-request sequence,
// and randomized fetches scored against a transaction-level model of the buffer and cache.
module tb_inst_fetch;

  localparam int unsigned TMO = 4;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        icache_flush;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall;
  logic        fetch_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: last-fetch buffer and an 8-line direct-mapped cache.
  logic [31:0] m_buf_addr;
  logic [31:0] m_buf_data;
  bit          m_buf_valid;
  bit          m_buf_err;
  bit          c_valid [8];
  logic [26:0] c_tag   [8];
  logic [31:0] c_data  [8];

  typedef struct {
    logic [31:0] a;
    int          dly;
    bit          fl_before;
    bit          fl_ack;
    int          ereq;
    logic [31:0] einst;
    logic        eerr;
  } vec_t;

  vec_t vecs [11];

  inst_fetch #(.MEM_TIMEOUT(TMO), .ICACHE_IDX(3)) dut (
    .clk_cpu      (clk_cpu),
    .reset        (reset),
    .pc           (pc),
    .icache_flush (icache_flush),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .stall        (stall),
    .fetch_err    (fetch_err),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk_cpu = ~clk_cpu;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h2108_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_buf_valid = 1'b0;
    for (int i = 0; i < 8; i++) c_valid[i] = 1'b0;
  endtask

  // ereq = cycles mem_req is high (0 = served without a bus access).
  task automatic predict(input logic [31:0] a, input int dly,
                         output int ereq, output logic [31:0] einst, output logic eerr);
    if (a[1:0] != 2'b00) begin
      ereq = 0; einst = 32'h0; eerr = 1'b1;
    end else if (m_buf_valid && m_buf_addr == a) begin
      ereq = 0; einst = m_buf_data; eerr = m_buf_err;
`ifdef INST_FETCH_ICACHE_EN
    end else if (c_valid[a[4:2]] && c_tag[a[4:2]] == a[31:5]) begin
      ereq = 0; einst = c_data[a[4:2]]; eerr = 1'b0;
`endif
    end else if (dly >= 1 && dly <= int'(TMO)) begin
      ereq = dly; einst = mem_word(a); eerr = 1'b0;
    end else begin
      ereq = int'(TMO); einst = 32'h0; eerr = 1'b1;
    end
  endtask

  task automatic commit(input logic [31:0] a, input int dly, input bit fl_ack);
    int          ereq;
    logic [31:0] einst;
    logic        eerr;
    predict(a, dly, ereq, einst, eerr);
    if (ereq != 0) begin
      if (fl_ack && !eerr) model_clear();
      m_buf_addr  = a;
      m_buf_data  = einst;
      m_buf_valid = 1'b1;
      m_buf_err   = eerr;
      if (!eerr && !fl_ack) begin
        c_valid[a[4:2]] = 1'b1;
        c_tag[a[4:2]]   = a[31:5];
        c_data[a[4:2]]  = einst;
      end
    end
  endtask

  task automatic do_flush();
    icache_flush = 1'b1;
    @(posedge clk_cpu); #1;
    icache_flush = 1'b0;
    model_clear();
  endtask

  // Presents pc, plays memory (ack once mem_req has been high dly cycles; 0 = never), checks result.
  task automatic fetch(input string tag, input logic [31:0] a, input int dly, input bit fl_ack,
                       input int ereq, input logic [31:0] einst, input logic eerr);
    int          reqs = 0;
    int          lat = -1;
    bit          stall_ok = 1'b1;
    bit          addr_ok = 1'b1;
    logic [31:0] got_inst = 32'hx;
    logic        got_err = 1'bx;
    pc = a;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      if (mem_req === 1'b1) begin
        reqs++;
        if (mem_addr !== a) addr_ok = 1'b0;
      end
      mem_ack      = (mem_req === 1'b1) && (dly > 0) && (reqs == dly);
      mem_rdata    = mem_ack ? mem_word(a) : 32'hDEAD_BEEF;
      icache_flush = mem_ack && fl_ack;
      #4;
      if (inst_valid === 1'b1) begin
        lat      = c;
        got_inst = inst;
        got_err  = fetch_err;
        if (stall !== 1'b0 || mem_req !== 1'b0) stall_ok = 1'b0;
      end else if (stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
      @(posedge clk_cpu); #1;
      mem_ack      = 1'b0;
      icache_flush = 1'b0;
    end
    check({tag, ".latency"}, lat, (ereq == 0) ? 0 : ereq + 1);
    check({tag, ".req_cycles"}, reqs, ereq);
    check({tag, ".inst"}, got_inst, einst);
    check({tag, ".fetch_err"}, got_err, eerr);
    check({tag, ".stall"}, stall_ok, 1);
    check({tag, ".mem_addr"}, addr_ok, 1);
  endtask

  initial begin
    reset        = 1'b1;
    pc           = 32'h0;
    icache_flush = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = 32'h0;
    model_clear();

    vecs[0]  = '{32'h0000_0000, 3, 1'b0, 1'b0, 3, 32'h2108_0001, 1'b0};
    vecs[1]  = '{32'h0000_0004, 1, 1'b0, 1'b0, 1, mem_word(32'h4), 1'b0};
`ifdef INST_FETCH_ICACHE_EN
    vecs[2]  = '{32'h0000_0000, 2, 1'b0, 1'b0, 0, 32'h2108_0001, 1'b0};
`else
    vecs[2]  = '{32'h0000_0000, 2, 1'b0, 1'b0, 2, 32'h2108_0001, 1'b0};
`endif
    vecs[3]  = '{32'h0000_0006, 1, 1'b0, 1'b0, 0, 32'h0, 1'b1};
    vecs[4]  = '{32'h0000_0040, 0, 1'b0, 1'b0, int'(TMO), 32'h0, 1'b1};
    vecs[5]  = '{32'h0000_0040, 0, 1'b0, 1'b0, 0, 32'h0, 1'b1};
    vecs[6]  = '{32'h0000_0040, 2, 1'b1, 1'b0, 2, mem_word(32'h40), 1'b0};
    vecs[7]  = '{32'h0000_0008, 2, 1'b0, 1'b1, 2, mem_word(32'h8), 1'b0};
    vecs[8]  = '{32'h0000_0008, 1, 1'b0, 1'b0, 0, mem_word(32'h8), 1'b0};
    vecs[9]  = '{32'h0000_000C, 1, 1'b0, 1'b0, 1, mem_word(32'hC), 1'b0};
    vecs[10] = '{32'h0000_0008, 1, 1'b0, 1'b0, 1, mem_word(32'h8), 1'b0};

    repeat (2) @(posedge clk_cpu);
    #1;
    check("rst.inst", inst, 32'h0);
    check("rst.inst_valid", inst_valid, 0);
    check("rst.fetch_err", fetch_err, 0);
    check("rst.stall", stall, 1);
    check("rst.mem_req", mem_req, 0);
    check("rst.mem_addr", mem_addr, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].fl_before) do_flush();
      fetch($sformatf("vec%0d", i), vecs[i].a, vecs[i].dly, vecs[i].fl_ack,
            vecs[i].ereq, vecs[i].einst, vecs[i].eerr);
      commit(vecs[i].a, vecs[i].dly, vecs[i].fl_ack);
    end

    // Reset in the second REQ cycle, then a stale ack one cycle later.
    pc = 32'h0000_0010;
    @(posedge clk_cpu); #1;
    check("rstreq.req_up", mem_req, 1);
    @(posedge clk_cpu); #1;
    reset = 1'b1;
    #1;
    check("rstreq.req_drop", mem_req, 0);
    check("rstreq.stall", stall, 1);
    check("rstreq.inst_valid", inst_valid, 0);
    check("rstreq.fetch_err", fetch_err, 0);
    @(posedge clk_cpu); #1;
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0BAD;
    #3;
    check("rstreq.ack_ignored", inst_valid, 0);
    @(posedge clk_cpu); #1;
    mem_ack = 1'b0;
    check("rstreq.reissue", mem_req, 1);
    check("rstreq.reissue_addr", mem_addr, 32'h0000_0010);
    mem_ack   = 1'b1;
    mem_rdata = mem_word(32'h10);
    @(posedge clk_cpu); #1;
    mem_ack = 1'b0;
    #3;
    check("rstreq.valid", inst_valid, 1);
    check("rstreq.inst", inst, mem_word(32'h10));
    @(posedge clk_cpu); #1;
    model_clear();
    commit(32'h0000_0010, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      int          d;
      bit          fb;
      bit          fa;
      int          er;
      logic [31:0] ei;
      logic        ee;
      a = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      d  = $urandom_range(0, 4);
      fb = ($urandom_range(0, 7) == 0);
      fa = ($urandom_range(0, 5) == 0);
      if (fb) do_flush();
      predict(a, d, er, ei, ee);
      fetch($sformatf("rnd%0d", i), a, d, fa, er, ei, ee);
      commit(a, d, fa);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage. It sits between `program_counter` and the CPU's decode/ALU path. It takes the current `pc`, returns the 32-bit instruction word as `inst`, and raises `stall` while the word is not yet available; the CPU top holds `pc` and the architectural state while `stall` is high. Misses go to instruction memory over a req/ack bus. An optional direct-mapped instruction cache gives zero-latency hits.

## Interface
- `MEM_TIMEOUT`, 255: cycles with `mem_req` high and no `mem_ack` before the fetch is aborted as a fetch error.
- `ICACHE_IDX`, 3: index width; the cache has 2^`ICACHE_IDX` one-word lines. Ignored without `ICACHE_EN`.
- `clk_cpu`  in  1  CPU clock.
- `reset`  in  1  asynchronous, active-high.
- `pc`  in  32  fetch address from `program_counter`.
- `icache_flush`  in  1  one-cycle pulse; invalidates the buffer and all cache lines.
- `inst`  out  32  instruction word for `pc`; valid only when `inst_valid` is 1.
- `inst_valid`  out  1  `inst` corresponds to the current `pc`.
- `stall`  out  1  fetch in progress; hold `pc`.
- `fetch_err`  out  1  the current `inst` is a bus timeout or a misaligned `pc`. The CPU top routes this to `CP_EXCP`.
- `mem_req`  out  1  registered bus request.
- `mem_addr`  out  32  registered word address, `{pc[31:2],2'b00}`.
- `mem_ack`  in  1  the data in `mem_rdata` is valid this cycle.
- `mem_rdata`  in  32  read data.

## Operation
- Registers: `f_addr`, `f_data`, `f_valid`, `f_err` (the last-fetch buffer); FSM state; timeout counter (8 bits min, sized to `MEM_TIMEOUT`); cache arrays (if `ICACHE_EN`).
- FSM has two states, `IDLE` and `REQ`.
- **Hit**: `f_valid && f_addr==pc`, or a cache hit.
  - On a hit: `inst_valid`=1, `stall`=0, `inst` = hit data, `fetch_err` = `f_err` (buffer hit) or 0 (cache hit).
- **Misaligned pc** (`pc[1:0]!=0`) in `IDLE`:
  - No bus access.
  - `inst`=32'h0, `inst_valid`=1, `fetch_err`=1, `stall`=0.
- **Miss** in `IDLE` with aligned `pc`:
  - Combinational outputs: `stall`=1, `inst_valid`=0.
  - Next edge: latch `f_addr`=`pc`, set `mem_addr`=`pc`, `mem_req`=1, clear the counter, go to `REQ`.
- **`REQ`**:
  - `stall`=1 and `inst_valid`=0 for the whole state.
  - `mem_req` and `mem_addr` are held stable until an edge where `mem_ack`=1.
  - On that edge: `f_data`=`mem_rdata`, `f_valid`=1, `f_err`=0, cache line filled, `mem_req`=0, go to `IDLE`.
- **Timeout**: the counter reaches `MEM_TIMEOUT` in `REQ` with no ack.
  - `f_data`=0, `f_valid`=1, `f_err`=1, `mem_req`=0, go to `IDLE`.
  - The cache is not filled.
- `mem_ack` while `mem_req`=0 is ignored.
- **`pc` changes during `REQ`** (protocol violation): the request completes for `f_addr`. The miss is then re-evaluated in `IDLE` against the new `pc`.
- **`icache_flush`**:
  - Clears `f_valid` and all cache valid bits at the next edge.
  - If asserted on the same edge as an ack, the flush wins for the cache, and the buffer still takes the data.
  - Flush does not abort `REQ`.
- **Reset** (any time, including mid-`REQ`): state goes to `IDLE`, `mem_req`=0, `mem_addr`=0, counter=0, `f_valid`=0, `f_err`=0, `f_data`=0, cache valid bits cleared. An ack arriving after reset is ignored.
- **Output values during reset** with aligned `pc`: `inst`=0, `inst_valid`=0, `fetch_err`=0, `stall`=1.

## Timing
- Hit: 0 cycles. `inst` is combinational from `pc` in the same cycle.
- Miss: the miss is seen in cycle 0; `mem_req` rises at edge 1. The ack is sampled at edge k≥2, and `inst_valid` is 1 in cycle k. Minimum miss latency is 2 cycles.
- `mem_req` falls at the same edge the ack is sampled. Back-to-back misses therefore have at least 1 low cycle on `mem_req` between requests.
- Timeout: `mem_req` is high for exactly `MEM_TIMEOUT` cycles, then `fetch_err`=1 in the following `IDLE` cycle.

## Configuration
- `INST_FETCH_ICACHE_EN` defined: adds a 2^`ICACHE_IDX`-line direct-mapped cache.
  - Index `pc[ICACHE_IDX+1:2]`; tag `pc[31:ICACHE_IDX+2]`; one valid bit per line.
  - Lines are filled on an ack only.
- `INST_FETCH_ICACHE_EN` undefined: only the one-entry buffer exists. Every `pc` change is a miss unless it equals `f_addr`.

## Test plan
- **Reset, then miss**: reset with `pc`=32'h0, memory acks 3 cycles after `mem_req` rises with data 32'h2108_0001.
  - `stall`=1 until `inst`=32'h2108_0001 with `inst_valid`=1.
  - `mem_req` was high for exactly 3 cycles; `mem_addr`=0.
- **Repeat hit** (`INST_FETCH_ICACHE_EN`): fetch 0x0, 0x4, then 0x0 again.
  - The third fetch has `stall`=0, no `mem_req`, and the same data as the first.
- **Misaligned `pc`**: `pc`=32'h0000_0006.
  - `inst`=0, `fetch_err`=1, `inst_valid`=1, `mem_req` stays 0.
- **Timeout**: `MEM_TIMEOUT`=4, never ack.
  - `mem_req` high for 4 cycles, then `fetch_err`=1, `inst`=0, `stall`=0.
  - Refetch of the same `pc` after `icache_flush` reissues `mem_req`.
- **Reset mid-`REQ`**: assert `reset` in cycle 2 of `REQ`, ack arrives 1 cycle later.
  - `mem_req` is 0 immediately and the ack is ignored.
  - The post-reset fetch reissues the request.
- **Flush/fill collision**: `icache_flush` on the same edge as an ack for 0x8.
  - The next access to 0x8 hits the buffer.
  - After fetching 0xC, a return to 0x8 misses and raises `mem_req`.
